// File: rtl/psram_pkg.sv
// Shared command codes, frame geometry and FSM state type for the QSPI PSRAM responder.
package psram_pkg;

    localparam logic [7:0] CMD_QREAD       = 8'hEB;
    localparam logic [7:0] CMD_QWRITE      = 8'h38;
    localparam int         ADDR_BITS_TOTAL = 24;
    localparam int         ADDR_NIBBLES    = ADDR_BITS_TOTAL / 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    function automatic logic cmd_supported(input logic [7:0] cmd);
        return (cmd == CMD_QREAD) || (cmd == CMD_QWRITE);
    endfunction

endpackage

// File: rtl/psram_target_mem.sv
// Single-port synchronous byte RAM backing the PSRAM responder (1-cycle read latency).
module psram_target_mem #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    // Read-before-write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/psram_qspi_target.sv
// QSPI PSRAM responder: oversamples SCK/CE_N/D on clk, decodes quad read/write, serves a byte RAM.
// ADDR_W must be at least 5 and DUMMY_CYC at least 1.
module psram_qspi_target
    import psram_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DUMMY_CYC = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       psram_sck,
    input  logic       psram_ce_n,
    input  logic [3:0] psram_d_in,
    output logic [3:0] psram_d_out,
    output logic [3:0] psram_d_oe,
    output logic       cmd_err,
    output logic       busy
);

    localparam int                  DCNT_W     = (DUMMY_CYC > 1) ? $clog2(DUMMY_CYC) : 1;
    localparam logic [DCNT_W-1:0]   DUMMY_LAST = DCNT_W'(DUMMY_CYC - 1);
    localparam logic [2:0]          ADDR_LAST  = 3'(ADDR_NIBBLES - 1);

    logic [1:0]        sck_sync;
    logic [1:0]        ce_sync;
    logic [3:0]        d_sync0;
    logic [3:0]        d_sync1;
    logic              sck_prev;
    logic              ce_prev;
    logic              sck_s;
    logic              ce_s;
    logic [3:0]        d_s;
    logic              sck_rise;
    logic              sck_fall;

    state_t            state;
    state_t            state_next;
    logic [2:0]        nib_cnt;
    logic [DCNT_W-1:0] dummy_cnt;
    logic              half;
    logic [7:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_shift;
    logic [3:0]        wr_hi;
    logic [3:0]        rd_lo;
    logic [3:0]        d_out_q;
    logic              oe_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    assign sck_s       = sck_sync[1];
    assign ce_s        = ce_sync[1];
    assign d_s         = d_sync1;
    assign sck_rise    = sck_s & ~sck_prev;
    assign sck_fall    = ~sck_s & sck_prev;
    assign psram_d_out = d_out_q;
    assign psram_d_oe  = {4{oe_q}};
    assign busy        = (state != ST_IDLE);

    psram_target_mem #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Two-flop synchronizers; data shares SCK's latency so a detected edge sees aligned data.
    always_ff @(posedge clk) begin
        sck_sync <= {sck_sync[0], psram_sck};
        ce_sync  <= {ce_sync[0], psram_ce_n};
        d_sync0  <= psram_d_in;
        d_sync1  <= d_sync0;
        sck_prev <= sck_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus memory port steering (start-address fetch, write commit).
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = {wr_hi, d_s};
        addr_shift = {addr_q[ADDR_W-5:0], d_s};
        if (ce_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ce_prev) begin
                        state_next = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sck_rise && nib_cnt == 3'd1) begin
                        state_next = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise && nib_cnt == ADDR_LAST) begin
                        mem_addr = addr_shift;
                        if (cmd_q == CMD_QREAD) begin
                            state_next = ST_DUMMY;
                        end else if (cmd_q == CMD_QWRITE) begin
                            state_next = ST_WDATA;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise && dummy_cnt == DUMMY_LAST) begin
                        state_next = ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (sck_rise && half) begin
                        mem_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame datapath: nibble counters, command/address capture, read drive and write assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_prev   <= 1'b0;
            nib_cnt   <= '0;
            dummy_cnt <= '0;
            half      <= 1'b0;
            cmd_q     <= '0;
            addr_q    <= '0;
            wr_hi     <= '0;
            rd_lo     <= '0;
            d_out_q   <= '0;
            oe_q      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            ce_prev <= ce_s;
            cmd_err <= 1'b0;
            if (ce_s) begin
                nib_cnt   <= '0;
                dummy_cnt <= '0;
                half      <= 1'b0;
                d_out_q   <= '0;
                oe_q      <= 1'b0;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (sck_rise) begin
                            cmd_q <= {cmd_q[3:0], d_s};
                            if (nib_cnt == 3'd1) begin
                                nib_cnt <= '0;
                                cmd_err <= !cmd_supported({cmd_q[3:0], d_s});
                            end else begin
                                nib_cnt <= nib_cnt + 3'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            addr_q  <= addr_shift;
                            nib_cnt <= nib_cnt + 3'd1;
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_rise) begin
                            dummy_cnt <= dummy_cnt + 1'b1;
                        end
                    end
                    ST_RDATA: begin
                        if (sck_fall) begin
                            oe_q <= 1'b1;
                            half <= ~half;
                            if (!half) begin
                                d_out_q <= mem_rdata[7:4];
                                rd_lo   <= mem_rdata[3:0];
                                addr_q  <= addr_q + 1'b1;
                            end else begin
                                d_out_q <= rd_lo;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) begin
                            half <= ~half;
                            if (!half) begin
                                wr_hi <= d_s;
                            end else begin
                                addr_q <= addr_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_qspi_target.sv
// Self-checking bench for psram_qspi_target: acts as the QSPI controller and keeps a byte-array model.
module tb_psram_qspi_target;

    localparam int HALF  = 4;
    localparam int DUMMY = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       psram_sck;
    logic       psram_ce_n;
    logic [3:0] psram_d_in;
    logic [3:0] psram_d_out;
    logic [3:0] psram_d_oe;
    logic       cmd_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int err_cycles = 0;

    logic [7:0] model [0:4095];
    logic [7:0] wbuf [0:15];
    logic [7:0] rbuf [0:15];
    logic       last_oe;
    logic       oe_pre;
    logic       oe_data;
    logic       oe_any;
    logic       oe_split;
    logic       busy_all;
    logic       busy_any;

    psram_qspi_target #(
        .ADDR_W    (12),
        .DUMMY_CYC (DUMMY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .psram_sck   (psram_sck),
        .psram_ce_n  (psram_ce_n),
        .psram_d_in  (psram_d_in),
        .psram_d_out (psram_d_out),
        .psram_d_oe  (psram_d_oe),
        .cmd_err     (cmd_err),
        .busy        (busy)
    );

    // System clock.
    always #5 clk = ~clk;

    // Count clk cycles during which cmd_err is high.
    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_cycles++;
    end

    // One SCK cycle: drive tx in the low phase, rise, sample the target's nibble, fall.
    task automatic xfer(input logic [3:0] tx, output logic [3:0] rx);
        psram_d_in = tx;
        repeat (HALF) @(negedge clk);
        psram_sck = 1'b1;
        rx = psram_d_out;
        last_oe = psram_d_oe[0];
        if (psram_d_oe[0]) oe_any = 1'b1;
        if (psram_d_oe !== {4{psram_d_oe[0]}}) oe_split = 1'b1;
        if (busy !== 1'b1) busy_all = 1'b0;
        if (busy === 1'b1) busy_any = 1'b1;
        repeat (HALF) @(negedge clk);
        psram_sck = 1'b0;
    endtask

    task automatic frame_header(input logic [7:0] cmd, input logic [23:0] addr);
        logic [31:0] hdr;
        logic [3:0]  junk;
        hdr = {cmd, addr};
        oe_pre = 1'b0; oe_data = 1'b1; oe_any = 1'b0; busy_all = 1'b1; busy_any = 1'b0;
        psram_ce_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xfer(hdr[31-4*i -: 4], junk);
            if (last_oe) oe_pre = 1'b1;
        end
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        psram_ce_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Full frame: header, dummies, n_wr bytes from wbuf, n_rd bytes into rbuf, n_tail stray nibbles.
    task automatic run_frame(input logic [7:0] cmd, input logic [23:0] addr, input int n_dummy,
                             input int n_wr, input int n_rd, input int n_tail, input logic [3:0] tail);
        logic [3:0] hi;
        logic [3:0] lo;
        logic [3:0] junk;
        frame_header(cmd, addr);
        for (int i = 0; i < n_dummy; i++) begin
            xfer(4'($urandom), junk);
            if (last_oe) oe_pre = 1'b1;
        end
        for (int i = 0; i < n_wr; i++) begin
            xfer(wbuf[i][7:4], junk);
            xfer(wbuf[i][3:0], junk);
        end
        for (int i = 0; i < n_rd; i++) begin
            xfer(4'($urandom), hi);
            if (!last_oe) oe_data = 1'b0;
            xfer(4'($urandom), lo);
            if (!last_oe) oe_data = 1'b0;
            rbuf[i] = {hi, lo};
        end
        for (int i = 0; i < n_tail; i++) begin
            xfer(tail, junk);
        end
        frame_end();
    endtask

    // Quad write of wbuf[0..n-1]; the model stores complete bytes at wrapped 12-bit addresses.
    task automatic do_write(input logic [23:0] addr, input int n, input int n_tail, input logic [3:0] tail);
        run_frame(8'h38, addr, 0, n, 0, n_tail, tail);
        for (int i = 0; i < n; i++) begin
            model[addr[11:0] + 12'(i)] = wbuf[i];
        end
    endtask

    task automatic do_read(input logic [23:0] addr, input int n);
        run_frame(8'hEB, addr, DUMMY, 0, n, 0, 4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1; psram_sck = 1'b0; psram_ce_n = 1'b1; psram_d_in = 4'h0;
        repeat (4) @(negedge clk);
        checks++; if (psram_d_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_d_out got %h exp 0", psram_d_out); end
        checks++; if (psram_d_oe !== 4'h0) begin errors++; $display("[TB] FAIL reset_d_oe got %h exp 0", psram_d_oe); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_err got %b exp 0", cmd_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int e0;
        logic [7:0] exp;
        e0 = err_cycles;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        do_write(24'h000010, 2, 0, 4'h0);
        do_read(24'h000010, 2);
        for (int i = 0; i < 2; i++) begin
            exp = model[12'h010 + 12'(i)];
            checks++; if (rbuf[i] !== exp) begin errors++; $display("[TB] FAIL basic_rd%0d got %h exp %h", i, rbuf[i], exp); end
        end
        checks++; if (oe_pre !== 1'b0) begin errors++; $display("[TB] FAIL basic_oe_early got %b exp 0", oe_pre); end
        checks++; if (oe_data !== 1'b1) begin errors++; $display("[TB] FAIL basic_oe_data got %b exp 1", oe_data); end
        checks++; if (busy_all !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b exp 1", busy_all); end
        checks++; if (err_cycles - e0 != 0) begin errors++; $display("[TB] FAIL basic_cmd_err got %0d cycles exp 0", err_cycles - e0); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(24'h000FFF, 2, 0, 4'h0);
        do_read(24'h000FFF, 1);
        exp = model[12'hFFF];
        checks++; if (rbuf[0] !== exp) begin errors++; $display("[TB] FAIL wrap_fff got %h exp %h", rbuf[0], exp); end
        do_read(24'h000000, 1);
        exp = model[12'h000];
        checks++; if (rbuf[0] !== exp) begin errors++; $display("[TB] FAIL wrap_000 got %h exp %h", rbuf[0], exp); end
        do_read(24'h000FFF, 2);
        for (int i = 0; i < 2; i++) begin
            exp = model[12'hFFF + 12'(i)];
            checks++; if (rbuf[i] !== exp) begin errors++; $display("[TB] FAIL wrap_stream%0d got %h exp %h", i, rbuf[i], exp); end
        end
    endtask

    task automatic test_bad_cmd();
        int e0;
        logic [7:0] exp;
        e0 = err_cycles;
        run_frame(8'h9F, 24'h000000, 0, 0, 2, 0, 4'h0);
        checks++; if (err_cycles - e0 != 1) begin errors++; $display("[TB] FAIL badcmd_pulse got %0d cycles exp 1", err_cycles - e0); end
        checks++; if (oe_any !== 1'b0) begin errors++; $display("[TB] FAIL badcmd_oe got %b exp 0", oe_any); end
        do_read(24'h000000, 1);
        exp = model[12'h000];
        checks++; if (rbuf[0] !== exp) begin errors++; $display("[TB] FAIL badcmd_mem got %h exp %h", rbuf[0], exp); end
    endtask

    task automatic test_partial();
        logic [7:0] exp;
        wbuf[0] = 8'($urandom);
        do_write(24'h000021, 1, 0, 4'h0);
        wbuf[0] = 8'h77;
        do_write(24'h000020, 1, 1, 4'hB);
        do_read(24'h000020, 2);
        for (int i = 0; i < 2; i++) begin
            exp = model[12'h020 + 12'(i)];
            checks++; if (rbuf[i] !== exp) begin errors++; $display("[TB] FAIL partial_rd%0d got %h exp %h", i, rbuf[i], exp); end
        end
    endtask

    task automatic test_alias();
        logic [7:0] exp;
        wbuf[0] = 8'h5A;
        do_write(24'hAB0010, 1, 0, 4'h0);
        do_read(24'h000010, 1);
        exp = model[12'h010];
        checks++; if (rbuf[0] !== exp) begin errors++; $display("[TB] FAIL alias got %h exp %h", rbuf[0], exp); end
    endtask

    task automatic test_rst_mid();
        logic [3:0] junk;
        logic [7:0] exp;
        frame_header(8'hEB, 24'h000010);
        for (int i = 0; i < DUMMY; i++) xfer(4'h0, junk);
        xfer(4'h0, junk);
        checks++; if (psram_d_oe !== 4'hF) begin errors++; $display("[TB] FAIL rstmid_oe_before got %h exp f", psram_d_oe); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (psram_d_oe !== 4'h0) begin errors++; $display("[TB] FAIL rstmid_oe got %h exp 0", psram_d_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (psram_d_out !== 4'h0) begin errors++; $display("[TB] FAIL rstmid_d_out got %h exp 0", psram_d_out); end
        rst = 1'b0;
        oe_any = 1'b0; busy_any = 1'b0;
        for (int i = 0; i < 4; i++) xfer(4'($urandom), junk);
        checks++; if (busy_any !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_tail_busy got %b exp 0", busy_any); end
        checks++; if (oe_any !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_tail_oe got %b exp 0", oe_any); end
        frame_end();
        do_read(24'h000010, 1);
        exp = model[12'h010];
        checks++; if (rbuf[0] !== exp) begin errors++; $display("[TB] FAIL rstmid_next got %h exp %h", rbuf[0], exp); end
    endtask

    task automatic test_random();
        logic [23:0] a;
        logic [23:0] ra;
        logic [7:0]  exp;
        int          n;
        oe_split = 1'b0;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 4);
            a = 24'($urandom);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(a, n, $urandom_range(0, 1), 4'($urandom));
            ra = {12'($urandom), a[11:0]};
            do_read(ra, n);
            for (int i = 0; i < n; i++) begin
                exp = model[a[11:0] + 12'(i)];
                checks++; if (rbuf[i] !== exp) begin errors++; $display("[TB] FAIL rand%0d_b%0d got %h exp %h", it, i, rbuf[i], exp); end
            end
        end
        checks++; if (oe_split !== 1'b0) begin errors++; $display("[TB] FAIL oe_lanes_equal got %b exp 0", oe_split); end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_bad_cmd();
        test_partial();
        test_alias();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
